// File: rtl/clk_cal_pkg.sv
// Shared definitions for the clock/calendar board front end:
// button channel indices, default timing constants and the repeat-state type.
package clk_cal_pkg;

    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_U = 2;
    localparam int BTN_C = 3;
    localparam int BTN_D = 4;

    // Cycle counts at the 100 MHz board clock
    localparam int DEBOUNCE_10MS = 1_000_000;
    localparam int REPEAT_500MS  = 50_000_000;
    localparam int REPEAT_200MS  = 20_000_000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// Single button channel: 2-flop synchroniser, counter debounce, press edge
// detect and, when BTN_AUTO_REPEAT_EN is defined, the hold-to-repeat FSM.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | button released (or press not yet debounced); rp_cnt held at 0
// HOLD   | press pulse issued, counting down the initial repeat delay
// REPEAT | issuing a repeat pulse every REPEAT_RATE cycles while held
module btn_debounce_ch
    import clk_cal_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int REPEAT_DELAY    = REPEAT_500MS,
    parameter int REPEAT_RATE     = REPEAT_200MS
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_err
        $error("btn_debounce_ch: timing parameters must be >= 1");
    end

    logic            s1;
    logic            s2;
    logic            stable;
    logic [DB_W-1:0] db_cnt;
    logic            db_done;
    logic            rise;

    assign db_done = (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
    assign rise    = s2 & ~stable & db_done;
    assign level   = stable;

    // Bring the asynchronous pin into the clock domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Flip the debounced level only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable <= 1'b0;
            db_cnt <= '0;
        end else if (s2 == stable) begin
            db_cnt <= '0;
        end else if (db_done) begin
            stable <= s2;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

`ifdef BTN_AUTO_REPEAT_EN
    localparam int RP_W = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);

    rep_state_t      state;
    rep_state_t      state_nxt;
    logic [RP_W-1:0] rp_cnt;
    logic            fall;
    logic            delay_done;
    logic            rate_done;
    logic            rep_fire;
    logic            rp_clr;

    assign fall       = ~s2 & stable & db_done;
    assign delay_done = (rp_cnt == RP_W'(REPEAT_DELAY - 1));
    assign rate_done  = (rp_cnt == RP_W'(REPEAT_RATE - 1));

    // Repeat FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state; a debounced release always wins over a pending repeat
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rise) state_nxt = HOLD;
            HOLD:    if (fall) state_nxt = IDLE;
                     else if (delay_done) state_nxt = REPEAT;
            REPEAT:  if (fall) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Repeat strobe and counter clear
    always_comb begin
        rep_fire = 1'b0;
        rp_clr   = 1'b0;
        case (state)
            IDLE: rp_clr = 1'b1;
            HOLD: begin
                if (fall) begin
                    rp_clr = 1'b1;
                end else if (delay_done) begin
                    rep_fire = 1'b1;
                    rp_clr   = 1'b1;
                end
            end
            REPEAT: begin
                if (fall) begin
                    rp_clr = 1'b1;
                end else if (rate_done) begin
                    rep_fire = 1'b1;
                    rp_clr   = 1'b1;
                end
            end
            default: rp_clr = 1'b1;
        endcase
    end

    // Repeat interval counter; cleared at every terminal count so it never wraps
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         rp_cnt <= '0;
        else if (rp_clr) rp_cnt <= '0;
        else             rp_cnt <= rp_cnt + 1'b1;
    end

    // Registered strobe: press edge or repeat tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pulse <= 1'b0;
        else     pulse <= rise | rep_fire;
    end
`else
    // Registered strobe: one pulse per debounced press, aligned with the level rising
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pulse <= 1'b0;
        else     pulse <= rise;
    end
`endif

endmodule

// File: rtl/btn_conditioner.sv
// Push-button front end for the clock/calendar top: per-channel synchronise,
// debounce and press-strobe generation for {btnD, btnC, btnU, btnR, btnL}.
// Defining BTN_AUTO_REPEAT_EN adds hold-to-repeat strobes on every channel.
module btn_conditioner
    import clk_cal_pkg::*;
#(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int REPEAT_DELAY    = REPEAT_500MS,
    parameter int REPEAT_RATE     = REPEAT_200MS
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE)
        ) u_ch (
            .clk   (clk_100MHz),
            .rst   (reset),
            .raw   (btn_raw[i]),
            .level (btn_level[i]),
            .pulse (btn_pulse[i])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_RATE=8. Edge numbering: inputs change just after edge 0, and outputs
// are sampled 1 ns after each later edge.
module tb_btn_conditioner;
    import clk_cal_pkg::*;

    localparam int NB = 5;

    logic          clk_100MHz = 1'b0;
    logic          reset      = 1'b1;
    logic [NB-1:0] btn_raw    = '0;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_pulse;

    int vectors     = 0;
    int miscompares = 0;

    btn_conditioner #(
        .N_BTN           (NB),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_RATE     (8)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_pulse  (btn_pulse)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic tick();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        btn_raw = '0;
        repeat (3) tick();
        vectors++;
        if (btn_level !== 5'b00000) begin
            miscompares++;
            $display("FAIL reset_level: got %b want %b", btn_level, 5'b00000);
        end
        vectors++;
        if (btn_pulse !== 5'b00000) begin
            miscompares++;
            $display("FAIL reset_pulse: got %b want %b", btn_pulse, 5'b00000);
        end
        #3 reset = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_clean_press();
        logic [NB-1:0] exp_l;
        logic [NB-1:0] exp_p;
        tick();
        btn_raw[BTN_L] = 1'b1;
        for (int e = 1; e <= 52; e++) begin
            tick();
            exp_l = '0;
            exp_p = '0;
            exp_l[BTN_L] = (e >= 6 && e < 46);
            exp_p[BTN_L] = (e == 6);
            vectors++;
            if (btn_level !== exp_l) begin
                miscompares++;
                $display("FAIL clean_level e=%0d: got %b want %b", e, btn_level, exp_l);
            end
            vectors++;
            if (btn_pulse !== exp_p) begin
                miscompares++;
                $display("FAIL clean_pulse e=%0d: got %b want %b", e, btn_pulse, exp_p);
            end
            if (e == 40) btn_raw[BTN_L] = 1'b0;
        end
        repeat (5) tick();
    endtask

    task automatic test_bounce();
        tick();
        btn_raw[BTN_R] = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            vectors++;
            if (btn_level !== 5'b00000 || btn_pulse !== 5'b00000) begin
                miscompares++;
                $display("FAIL bounce e=%0d: level %b pulse %b want 00000", e, btn_level, btn_pulse);
            end
            if (e == 3) btn_raw[BTN_R] = 1'b0;
            if (e == 5) btn_raw[BTN_R] = 1'b1;
            if (e == 8) btn_raw[BTN_R] = 1'b0;
        end
    endtask

    // Default build: a single press pulse. Repeat build: press at 6, repeats at 26, 34, ...
    task automatic test_auto_repeat();
        logic exp_p;
        logic exp_l;
        tick();
        btn_raw[BTN_U] = 1'b1;
        for (int e = 1; e <= 75; e++) begin
            tick();
`ifdef BTN_AUTO_REPEAT_EN
            exp_p = (e == 6 || e == 26 || e == 34 || e == 42 || e == 50 || e == 58);
`else
            exp_p = (e == 6);
`endif
            exp_l = (e >= 6 && e < 66);
            vectors++;
            if (btn_pulse[BTN_U] !== exp_p || btn_level[BTN_U] !== exp_l) begin
                miscompares++;
                $display("FAIL hold e=%0d: pulse %b level %b want pulse %b level %b",
                         e, btn_pulse[BTN_U], btn_level[BTN_U], exp_p, exp_l);
            end
            vectors++;
            if ((btn_pulse & 5'b11011) !== 5'b00000) begin
                miscompares++;
                $display("FAIL hold_others e=%0d: pulse %b want xx0xx", e, btn_pulse);
            end
            if (e == 60) btn_raw[BTN_U] = 1'b0;
        end
    endtask

    task automatic test_simultaneous();
        logic [NB-1:0] exp_v;
        tick();
        btn_raw[BTN_C] = 1'b1;
        btn_raw[BTN_D] = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            exp_v = (e == 6) ? 5'b11000 : 5'b00000;
            vectors++;
            if (btn_pulse !== exp_v) begin
                miscompares++;
                $display("FAIL simul_pulse e=%0d: got %b want %b", e, btn_pulse, exp_v);
            end
            exp_v = (e >= 6) ? 5'b11000 : 5'b00000;
            vectors++;
            if (btn_level !== exp_v) begin
                miscompares++;
                $display("FAIL simul_level e=%0d: got %b want %b", e, btn_level, exp_v);
            end
        end
        btn_raw = '0;
        repeat (10) tick();
    endtask

    task automatic test_reset_mid_hold();
        logic [NB-1:0] exp_l;
        logic [NB-1:0] exp_p;
        tick();
        btn_raw[BTN_L] = 1'b1;
        repeat (6) tick();
        vectors++;
        if (btn_pulse !== 5'b00001) begin
            miscompares++;
            $display("FAIL rst_prepulse: got %b want %b", btn_pulse, 5'b00001);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (btn_level !== 5'b00000 || btn_pulse !== 5'b00000) begin
            miscompares++;
            $display("FAIL rst_async: level %b pulse %b want 00000", btn_level, btn_pulse);
        end
        repeat (2) tick();
        vectors++;
        if (btn_level !== 5'b00000 || btn_pulse !== 5'b00000) begin
            miscompares++;
            $display("FAIL rst_held: level %b pulse %b want 00000", btn_level, btn_pulse);
        end
        #3 reset = 1'b0;
        // Button still held: fresh press, pulse on the sixth post-reset edge
        for (int f = 1; f <= 15; f++) begin
            tick();
            exp_l = (f >= 6) ? 5'b00001 : 5'b00000;
            exp_p = (f == 6) ? 5'b00001 : 5'b00000;
            vectors++;
            if (btn_pulse !== exp_p || btn_level !== exp_l) begin
                miscompares++;
                $display("FAIL rst_repress f=%0d: pulse %b level %b want pulse %b level %b",
                         f, btn_pulse, btn_level, exp_p, exp_l);
            end
        end
        btn_raw = '0;
        repeat (10) tick();
        vectors++;
        if (btn_level !== 5'b00000) begin
            miscompares++;
            $display("FAIL rst_release: got %b want %b", btn_level, 5'b00000);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_simultaneous();
        test_reset_mid_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
